risc32_div: RTL and testbench
=============================

// Module: risc32_div
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU, instantiated beside the EX stage.
//  Produces {remainder, quotient}; downstream WB writes remainder to HI and quotient to LO.
//  EX holds start_i high and stalls the pipeline until ready_o is asserted.
// PARAMETERS
//  DATA_W  32  operand width; counter width = $clog2(DATA_W)+1
// PORTS
//  clk          in   1         system clock, all state updates on rising edge
//  rst          in   1         synchronous, active-low reset (rst==0 resets on clk edge)
//  signed_i     in   1         1 = DIV (two's complement), 0 = DIVU
//  opdata1_i    in   DATA_W    dividend
//  opdata2_i    in   DATA_W    divisor
//  start_i      in   1         request; held high by EX until ready_o seen
//  annul_i      in   1         flush (branch/exception); aborts an in-progress divide
//  result_o     out  2*DATA_W  {remainder[63:32], quotient[31:0]}; zero unless ready_o
//  ready_o      out  1         result valid
//  busy_o       out  1         1 in BY_ZERO or ON
// BEHAVIOUR
//  Reset: state=FREE, result_o=0, ready_o=0, busy_o=0, counter=0, working regs=0.
//  Reset mid-operation aborts it, with no partial result.
//  FREE: on start_i=1 & annul_i=0: if opdata2_i==0 -> BY_ZERO;
//   otherwise latch |op1|,|op2| (abs only when signed_i), sign flags, cnt=0 -> ON.
//   In FREE, start_i with annul_i=1 is ignored.
//  BY_ZERO: one cycle; result register cleared -> END (result 0, defined by team).
//  ON: annul_i=1 -> FREE at next edge, with no result.
//   Else while cnt<32: shift {rem,quo} left 1; diff=rem[32:0]-{1'b0,divisor};
//   if diff>=0 take diff and set quo[0]=1, else quo[0]=0; cnt++.
//   At cnt==32: sign correction: negate quo if signed & (s1^s2);
//   negate rem if signed & s1. Then -> END.
//  END: result_o valid, ready_o=1; annul_i ignored; stay while start_i=1;
//   start_i=0 -> FREE, ready_o=0 and result_o=0 after that edge.
//  Latency: start sampled at edge E0 -> ready_o high after E34 (33 ON cycles).
//   Divide by zero -> ready_o after E2.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wrap).
//  Unsigned path never negates; abs() of 0x80000000 is 0x80000000 treated unsigned.
//  Operand changes after acceptance are ignored (operands are latched).
//  New request: accepted only from FREE, so back-to-back divides need one FREE cycle.
// STRUCTURE
//  risc32_consts.v: DIV_FREE/DIV_BY_ZERO/DIV_ON/DIV_END (2-bit);
//   Div_Result_Ready/Div_Result_Not_Ready; Div_Start/Div_Stop.
//  Optional sub-module risc32_div_step: combinational single iteration.
//   Input {rem,quo}, divisor; output next {rem,quo}.
//  Everything else (FSM, counter, sign fix) stays in this file.
// TESTING
//  1 DIVU 100/7 -> after E34 ready_o=1, result_o={0x2, 0xE}; drop start -> ready_o=0 next cycle.
//  2 DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF;
//    DIVU same operands -> q 0x7FFFFFFC, r 0x1.
//  3 op2=0 (either signedness) -> ready_o after E2, result_o=0; busy_o high exactly 1 cycle.
//  4 annul_i at ON cycle 10 -> FREE next edge, ready_o never rises;
//    start 2 cycles later -> correct 34-cycle result.
//  5 DIV 0x80000000/0xFFFFFFFF -> q 0x80000000, r 0;
//    DIVU 0xFFFFFFFF/1 -> q 0xFFFFFFFF, r 0.
//  6 rst=0 at ON cycle 20 -> all outputs 0 after that edge;
//    rst=1 with start held -> fresh divide, ready after 34 cycles.

Source files
------------

// File: rtl/risc32_div_pkg.sv
// Shared state encoding and handshake constants for the iterative divider.
package risc32_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/risc32_div_step.sv
// One combinational restoring-division iteration on the packed {remainder, quotient} word.
module risc32_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] rem_quo,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] next_rem_quo
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W-1:0] diff;
    logic              take;

    // Shift in the next dividend bit, then subtract the divisor when it fits.
    always_comb begin
        shifted = {rem_quo, 1'b0};
        take    = (shifted[2*DATA_W:DATA_W] >= {1'b0, divisor});
        // When the divisor fits, the true difference is below 2^DATA_W, so a
        // DATA_W-bit subtraction is exact.
        diff    = shifted[2*DATA_W-1:DATA_W] - divisor;
        if (take) begin
            next_rem_quo = {diff, shifted[DATA_W-1:1], 1'b1};
        end else begin
            next_rem_quo = shifted[2*DATA_W-1:0];
        end
    end

endmodule

// File: rtl/risc32_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module risc32_div
    import risc32_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        neg_if = neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_e          state_r;
    div_state_e          state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W-1:0] rem_quo_r;
    logic [2*DATA_W-1:0] step_s;
    logic [DATA_W-1:0]   divisor_r;
    logic                neg_quo_r;
    logic                neg_rem_r;
    logic                op1_neg_s;
    logic                op2_neg_s;
    logic                deliver_s;

    assign op1_neg_s = signed_i & opdata1_i[DATA_W-1];
    assign op2_neg_s = signed_i & opdata2_i[DATA_W-1];
    assign deliver_s = (state_r == DIV_END) && (start_i == DIV_START);

    risc32_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_quo      (rem_quo_r),
        .divisor      (divisor_r),
        .next_rem_quo (step_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= DIV_FREE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    state_s = (opdata2_i == {DATA_W{1'b0}}) ? DIV_BY_ZERO : DIV_ON;
                end else begin
                    state_s = DIV_FREE;
                end
            end
            DIV_BY_ZERO: state_s = DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    state_s = DIV_FREE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DIV_END;
                end else begin
                    state_s = DIV_ON;
                end
            end
            DIV_END: state_s = (start_i == DIV_STOP) ? DIV_FREE : DIV_END;
            default: state_s = DIV_FREE;
        endcase
    end

    // Operand latch, iteration and final sign correction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_quo_r <= {(2*DATA_W){1'b0}};
            divisor_r <= {DATA_W{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_FREE: begin
                    if (state_s == DIV_ON) begin
                        rem_quo_r <= {{DATA_W{1'b0}}, neg_if(opdata1_i, op1_neg_s)};
                        divisor_r <= neg_if(opdata2_i, op2_neg_s);
                        neg_quo_r <= op1_neg_s ^ op2_neg_s;
                        neg_rem_r <= op1_neg_s;
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                DIV_BY_ZERO: rem_quo_r <= {(2*DATA_W){1'b0}};
                DIV_ON: begin
                    if (!annul_i) begin
                        if (cnt_r == CNT_LAST) begin
                            rem_quo_r <= {neg_if(rem_quo_r[2*DATA_W-1:DATA_W], neg_rem_r),
                                          neg_if(rem_quo_r[DATA_W-1:0], neg_quo_r)};
                        end else begin
                            rem_quo_r <= step_s;
                            cnt_r     <= cnt_r + CNT_ONE;
                        end
                    end
                end
                default: rem_quo_r <= rem_quo_r;
            endcase
        end
    end

    // Registered handshake outputs; result is forced to zero whenever not ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_o <= {(2*DATA_W){1'b0}};
            ready_o  <= DIV_RESULT_NOT_READY;
            busy_o   <= 1'b0;
        end else begin
            result_o <= deliver_s ? rem_quo_r : {(2*DATA_W){1'b0}};
            ready_o  <= deliver_s ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
            busy_o   <= (state_s == DIV_BY_ZERO) || (state_s == DIV_ON);
        end
    end

endmodule

// File: tb/tb_risc32_div.sv
// Directed, table-driven bench for risc32_div with hand-computed quotients and remainders.
module tb_risc32_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    risc32_div #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
        int          busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Drives one request, scrambles operands after acceptance, waits for ready, then releases start.
    task automatic run_div(input vec_t v, input string tag);
        int lat    = -1;
        int busy_n = 0;
        signed_i  = v.sgn;
        opdata1_i = v.a;
        opdata2_i = v.b;
        annul_i   = 1'b0;
        start_i   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~v.sgn;
            end
            if (busy_o) busy_n++;
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        chk(tag, "latency", 64'(lat), 64'(v.lat));
        chk(tag, "result", result_o, v.res);
        chk(tag, "busy_cycles", 64'(busy_n), 64'(v.busy));
        start_i = 1'b0;
        @(posedge clk); #1;
        chk(tag, "ready_drop", {63'd0, ready_o}, 64'd0);
        chk(tag, "result_clear", result_o, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen_ready;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 34, 33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'h0000_0001, 32'h7FFF_FFFC}, 34, 33};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 34, 33};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}, 34, 33};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'd0,                           2,  1};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0,                           2,  1};
        vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 34, 33};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'h0000_000E}, 34, 33};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         {32'h0000_0003, 32'h0000_0000}, 34, 33};
        vecs[10] = '{1'b0, 32'hDEAD_BEEF,  32'h0000_0010,  {32'h0000_000F, 32'h0DEA_DBEE}, 34, 33};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,          {32'h0000_0000, 32'hC000_0000}, 34, 33};

        rst       = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "result", result_o, 64'd0);
        chk("reset", "ready", {63'd0, ready_o}, 64'd0);
        chk("reset", "busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i], $sformatf("vec%0d", i));
        end

        // Annul during ON cycle 10, then annul+start held in FREE must be ignored.
        signed_i   = 1'b0;
        opdata1_i  = 32'd100;
        opdata2_i  = 32'd7;
        start_i    = 1'b1;
        seen_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            seen_ready |= ready_o;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        chk("annul", "busy_after_flush", {63'd0, busy_o}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            seen_ready |= ready_o | busy_o;
        end
        chk("annul", "no_ready_or_busy", {63'd0, seen_ready}, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        run_div(vecs[0], "after_annul");

        // Reset during ON cycle 20, then release with start still held.
        signed_i   = vecs[1].sgn;
        opdata1_i  = vecs[1].a;
        opdata2_i  = vecs[1].b;
        start_i    = 1'b1;
        seen_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            seen_ready |= ready_o;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset", "result", result_o, 64'd0);
        chk("midreset", "ready", {63'd0, ready_o | seen_ready}, 64'd0);
        chk("midreset", "busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b1;
        run_div(vecs[1], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
